// File: rtl/serial_parity_transmitter.sv
// serial_parity_transmitter
//   Transmit side of the serial parity link. A parallel word is accepted on
//   valid & ready, shifted out LSB-first on x one bit per clock, and followed
//   by a single parity bit. A frame is DATA_W data bits plus 1 parity bit.
//   Back-to-back frames are possible without a gap. A word is accepted in the
//   cycle that carries the previous frame's parity bit.
//
// Parameters
//   DATA_W      data bits per frame (>= 1)
//   ODD_PARITY  0: even parity over the frame, 1: odd parity over the frame
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; abandons any frame in flight
//   data_in    in   word to transmit, sampled only on accept
//   valid      in   upstream offers data_in this cycle
//   ready      out  a word can be accepted this cycle (decode of state)
//   x          out  serial bit: data bits LSB-first, then the parity bit
//   x_valid    out  x carries a frame bit this cycle
//   frame_end  out  high together with the parity bit
//   busy       out  a frame is in progress
module serial_parity_transmitter #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              x,
  output logic              x_valid,
  output logic              frame_end,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                x_q, x_d;
  logic                x_valid_q, x_valid_d;
  logic                frame_end_q, frame_end_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                last_data;

  // The state describes what x is currently showing: SHIFT while a data bit
  // is on x, PARITY while the parity bit is on x. Because x is registered,
  // the first data bit is loaded on the accept edge itself. The shift
  // register therefore keeps only the bits still to be sent, and cnt_q is
  // the index of the data bit currently on x.
  assign ready     = (state_q == ST_IDLE) || (state_q == ST_PARITY);
  assign accept    = valid && ready;
  assign last_data = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      frame_end_q <= frame_end_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SHIFT;
      ST_SHIFT:  if (last_data) state_d = ST_PARITY;
      ST_PARITY: state_d = accept ? ST_SHIFT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    frame_end_d = 1'b0;

    if (accept) begin
      // Accept is only possible in IDLE or PARITY; both start a new frame
      // with bit 0 on x next cycle.
      x_d       = data_in[0];
      x_valid_d = 1'b1;
      acc_d     = ODD_PARITY ^ data_in[0];
      sreg_d    = data_in >> 1;
      cnt_d     = '0;
    end else if (state_q == ST_SHIFT) begin
      x_valid_d = 1'b1;
      if (last_data) begin
        // acc_q already folds in the data bit currently on x.
        x_d         = acc_q;
        frame_end_d = 1'b1;
      end else begin
        x_d    = sreg_q[0];
        acc_d  = acc_q ^ sreg_q[0];
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign frame_end = frame_end_q;
  assign busy      = busy_q;

  // Idle-line outputs are clean, and frame_end never appears without data.
  a_idle_clean : assert property (@(posedge clk) disable iff (reset)
    !x_valid |-> (!x && !frame_end));

  a_busy_state : assert property (@(posedge clk) disable iff (reset)
    busy == (state_q != ST_IDLE));

endmodule

// File: tb/tb_serial_parity_transmitter.sv
module tb_serial_parity_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready, x, xv, fe, busy;
  logic       ready_o, x_o, xv_o, fe_o, busy_o;
  logic       valid1;
  logic [0:0] data1;
  logic       ready1, x1, xv1, fe1, busy1;

  serial_parity_transmitter #(.DATA_W(8), .ODD_PARITY(1'b0)) u_dut (
    .clk(clk), .reset(rst), .data_in(data), .valid(valid), .ready(ready),
    .x(x), .x_valid(xv), .frame_end(fe), .busy(busy));

  serial_parity_transmitter #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .reset(rst), .data_in(data), .valid(valid), .ready(ready_o),
    .x(x_o), .x_valid(xv_o), .frame_end(fe_o), .busy(busy_o));

  serial_parity_transmitter #(.DATA_W(1), .ODD_PARITY(1'b0)) u_w1 (
    .clk(clk), .reset(rst), .data_in(data1), .valid(valid1), .ready(ready1),
    .x(x1), .x_valid(xv1), .frame_end(fe1), .busy(busy1));

  // Reference model: a queue of frame bits still to appear on x, head = now.
  typedef struct {
    logic be;    // bit for the even-parity instance
    logic bo;    // bit for the odd-parity instance
    logic last;  // parity bit of the frame
  } fbit_t;
  fbit_t q[$];

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
  } vec_t;
  vec_t tbl[7];

  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  logic chk_en = 1'b0;
  logic s_x, s_xv, s_fe, s_xo, s_ready, s_busy, s_ready_o, s_xv_o, s_fe_o;
  logic s_x1, s_xv1, s_fe1, s_ready1;
  logic p_chk = 1'b0;
  logic prev_fe = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: sample/compare at negedge, advance the model at posedge.
  task automatic cycle();
    logic [8:0] exp_v, got_v;
    logic       m_acc;
    fbit_t      e;
    @(negedge clk);
    s_x = x; s_xv = xv; s_fe = fe; s_xo = x_o; s_ready = ready; s_busy = busy;
    s_ready_o = ready_o; s_xv_o = xv_o; s_fe_o = fe_o;
    s_x1 = x1; s_xv1 = xv1; s_fe1 = fe1; s_ready1 = ready1;
    if (chk_en) begin
      if (q.size() > 0)
        exp_v = {(q.size() <= 1), 1'b1, 1'b1, q[0].be, q[0].last, q[0].bo,
                 (q.size() <= 1), 1'b1, q[0].last};
      else
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      got_v = {s_ready, s_busy, s_xv, s_x, s_fe, s_xo, s_ready_o, s_xv_o, s_fe_o};
      check("model_outputs", {7'b0, got_v}, {7'b0, exp_v});
      if (prev_fe) check("loopback_parity", {15'b0, p_chk}, 16'h0);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      m_acc = valid && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (m_acc) begin
        n_acc++;
        for (int i = 0; i < 8; i++) begin
          e.be = data[i]; e.bo = data[i]; e.last = 1'b0;
          q.push_back(e);
        end
        e.be = ^data; e.bo = ~(^data); e.last = 1'b1;
        q.push_back(e);
      end
    end
    p_chk   = rst ? 1'b0 : (p_chk ^ (s_x & s_xv));
    prev_fe = rst ? 1'b0 : s_fe;
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, output logic [7:0] got,
                           output logic par_e, output logic par_o, output logic [8:0] fe_mask);
    valid = 1'b1; data = d;
    cycle();
    valid = 1'b0; data = 8'($urandom);
    got = '0; fe_mask = '0; par_e = 1'b0; par_o = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (i < 8) got[i] = s_x;
      else begin par_e = s_x; par_o = s_xo; end
      fe_mask[i] = s_fe;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic       pe, po;
    logic [8:0] fm;
    int         nxv;
    logic [1:0] pars;

    tbl[0] = '{8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 1'b0, 1'b1};

    rst = 1'b1; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
    cycle();
    rst = 1'b0; chk_en = 1'b1;
    cycle();
    check("reset_state", {11'b0, s_ready, s_busy, s_xv, s_x, s_fe}, 16'h0010);

    // Table-driven frames, including A5 bit order and 07 even/odd parity.
    foreach (tbl[k]) begin
      run_frame(tbl[k].d, got, pe, po, fm);
      check("frame_data", {8'b0, got}, {8'b0, tbl[k].d});
      check("parity_even", {15'b0, pe}, {15'b0, tbl[k].pe});
      check("parity_odd", {15'b0, po}, {15'b0, tbl[k].po});
      check("frame_end_pos", {7'b0, fm}, 16'h0100);
    end

    // Back-to-back FF then 01 with valid held high.
    valid = 1'b1; data = 8'hFF; nxv = 0; pars = '0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c == 0) data = 8'h01;
      if (c == 9) valid = 1'b0;
      if (c >= 1 && c <= 18) nxv += int'(s_xv);
      if (c == 5) check("b2b_ready_shift", {15'b0, s_ready}, 16'h0);
      if (c == 9) begin pars[0] = s_x; check("b2b_ready_parity", {15'b0, s_ready}, 16'h1); end
      if (c == 18) pars[1] = s_x;
      if (c == 19) check("b2b_idle_after", {15'b0, s_xv}, 16'h0);
    end
    check("b2b_xvalid_count", 16'(nxv), 16'd18);
    check("b2b_parities", {14'b0, pars}, 16'h0002);

    // Reset after three data bits of 3C abandons the frame.
    valid = 1'b1; data = 8'h3C;
    cycle();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_midframe", {13'b0, s_xv, s_busy, s_ready}, 16'h0001);
    run_frame(8'h81, got, pe, po, fm);
    check("after_reset_data", {8'b0, got}, 16'h0081);
    check("after_reset_parity", {15'b0, pe}, 16'h0);

    // valid pulsed with other data during SHIFT is ignored.
    valid = 1'b1; data = 8'h5A;
    cycle();
    got = '0;
    for (int i = 0; i < 9; i++) begin
      valid = (i == 2 || i == 7); data = 8'hC3;
      cycle();
      if (i < 8) got[i] = s_x; else pe = s_x;
    end
    valid = 1'b0;
    check("ignore_valid_data", {8'b0, got}, 16'h005A);
    check("ignore_valid_parity", {15'b0, pe}, 16'h0);

    // Randomized traffic with loopback parity checking in every cycle.
    n_acc = 0;
    for (int c = 0; c < 5000 && n_acc < 200; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      cycle();
    end
    valid = 1'b0;
    check("random_accepts", 16'(n_acc >= 200), 16'h1);
    for (int i = 0; i < 12; i++) cycle();

    // DATA_W = 1 sweep.
    for (int d = 0; d < 2; d++) begin
      valid1 = 1'b1; data1 = 1'(d);
      cycle();
      valid1 = 1'b0;
      cycle();
      check("w1_data_bit", {12'b0, s_ready1, s_xv1, s_x1, s_fe1}, {12'b0, 1'b0, 1'b1, 1'(d), 1'b0});
      cycle();
      check("w1_parity_bit", {12'b0, s_ready1, s_xv1, s_x1, s_fe1}, {12'b0, 1'b1, 1'b1, 1'(d), 1'b1});
      cycle();
      check("w1_idle", {14'b0, s_ready1, s_xv1}, 16'h0002);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
